// File: rtl/cook_timer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cook_timer_ctrl_pkg
//   Shared definitions for the cook timer controller and its BCD mm:ss
//   down-counter.
//   - state_e       : controller FSM states with their fixed 2-bit codes
//   - ST_*          : the same codes as plain 2-bit constants
//   - bcd_t         : one 4-bit BCD digit
//   - SEC_TENS_WRAP : value the seconds-tens digit takes after a borrow (5)
//   - DIGIT_WRAP    : value any other digit takes after a borrow (9)
// ----------------------------------------------------------------------------
package cook_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COOK  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_WRAP = 4'd5;
    localparam bcd_t DIGIT_WRAP    = 4'd9;

    // Keypad codes 10-15 are not decimal digits.
    function automatic logic is_valid_digit(input bcd_t d);
        return (d <= DIGIT_WRAP);
    endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// ----------------------------------------------------------------------------
// bcd_mmss_down
//   Four-digit BCD mm:ss register with keypad shift-in and a one-second
//   down-count.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     clr_i         : clear all digits to zero (highest priority)
//     load_i        : shift left one digit, digit_i enters at seconds units
//     digit_i       : BCD digit to shift in
//     dec_i         : subtract one second (ignored at 00:00)
//     time_bcd_o    : {min_tens, min_units, sec_tens, sec_units}
//     is_zero_o     : time is 00:00
//     is_one_o      : time is 00:01 (next decrement reaches zero)
// ----------------------------------------------------------------------------
module bcd_mmss_down
    import cook_timer_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        load_i,
    input  bcd_t        digit_i,
    input  logic        dec_i,
    output logic [15:0] time_bcd_o,
    output logic        is_zero_o,
    output logic        is_one_o
);

    bcd_t min_tens_q, min_units_q, sec_tens_q, sec_units_q;
    bcd_t min_tens_d, min_units_d, sec_tens_d, sec_units_d;

    assign time_bcd_o = {min_tens_q, min_units_q, sec_tens_q, sec_units_q};
    assign is_zero_o  = (time_bcd_o == 16'h0000);
    assign is_one_o   = (time_bcd_o == 16'h0001);

    // Borrow chain: each digit only borrows when all lower digits are zero.
    // Seconds above 59 (keyed in as 60-99) simply count down digit by digit;
    // the seconds-tens wrap to 5 only happens when seconds reach 00.
    always_comb begin
        min_tens_d  = min_tens_q;
        min_units_d = min_units_q;
        sec_tens_d  = sec_tens_q;
        sec_units_d = sec_units_q;
        if (clr_i) begin
            min_tens_d  = '0;
            min_units_d = '0;
            sec_tens_d  = '0;
            sec_units_d = '0;
        end else if (load_i) begin
            min_tens_d  = min_units_q;
            min_units_d = sec_tens_q;
            sec_tens_d  = sec_units_q;
            sec_units_d = digit_i;
        end else if (dec_i && !is_zero_o) begin
            if (sec_units_q != '0) begin
                sec_units_d = sec_units_q - 4'd1;
            end else begin
                sec_units_d = DIGIT_WRAP;
                if (sec_tens_q != '0) begin
                    sec_tens_d = sec_tens_q - 4'd1;
                end else begin
                    sec_tens_d = SEC_TENS_WRAP;
                    if (min_units_q != '0) begin
                        min_units_d = min_units_q - 4'd1;
                    end else begin
                        min_units_d = DIGIT_WRAP;
                        min_tens_d  = min_tens_q - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_tens_q  <= '0;
            min_units_q <= '0;
            sec_tens_q  <= '0;
            sec_units_q <= '0;
        end else begin
            min_tens_q  <= min_tens_d;
            min_units_q <= min_units_d;
            sec_tens_q  <= sec_tens_d;
            sec_units_q <= sec_units_d;
        end
    end

endmodule

// File: rtl/cook_timer_ctrl.sv
// ----------------------------------------------------------------------------
// cook_timer_ctrl
//   Microwave cook-timer controller: keypad time entry, start/stop/clear
//   handling, door interlock and one-second countdown.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     tick_1hz     : one-clk pulse per second
//     startn       : start request, active low
//     stopn        : stop/pause request, active low
//     clearn       : clear request, active low
//     door_closed  : 1 = door closed
//     key_valid    : qualifies key_digit for one clk
//     key_digit    : BCD keypad digit (10-15 ignored)
//     mag_on       : magnetron enable, drops combinationally on door open
//     timer_done   : high in DONE
//     time_bcd     : remaining time {m10, m1, s10, s1}, registered
//     state        : FSM state code, registered
// ----------------------------------------------------------------------------
module cook_timer_ctrl
    import cook_timer_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        startn,
    input  logic        stopn,
    input  logic        clearn,
    input  logic        door_closed,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    output logic        mag_on,
    output logic        timer_done,
    output logic [15:0] time_bcd,
    output logic [1:0]  state
);

    state_e state_q, state_d;

    logic cnt_clr, cnt_load, cnt_dec;
    logic cnt_is_zero, cnt_is_one;

    bcd_mmss_down u_counter (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .digit_i    (key_digit),
        .dec_i      (cnt_dec),
        .time_bcd_o (time_bcd),
        .is_zero_o  (cnt_is_zero),
        .is_one_o   (cnt_is_one)
    );

    // Request priority: clear > door open > stop > start > tick > key.
    // Requests with no meaning in the current state fall through to the
    // next lower one (e.g. a held start button in COOK does not mask ticks).
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (!clearn) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!startn && door_closed && !cnt_is_zero) begin
                        state_d = COOK;
                    end else if (key_valid && is_valid_digit(key_digit)) begin
                        cnt_load = 1'b1;
                    end
                end
                COOK: begin
                    if (!door_closed || !stopn) begin
                        state_d = PAUSE;
                    end else if (tick_1hz) begin
                        cnt_dec = 1'b1;
                        if (cnt_is_one) begin
                            state_d = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (door_closed && stopn && !startn) begin
                        state_d = COOK;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Derived from the asynchronously reset state register, so reset and
    // door opening both remove the magnetron without waiting for clk.
    assign mag_on     = (state_q == COOK) && door_closed;
    assign timer_done = (state_q == DONE);
    assign state      = state_q;

endmodule

// File: doc/cook_timer_ctrl.md
COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 tick_1hz  input  1  one-clk-wide pulse once per second, synchronous to clk.
REQ-005 startn  input  1  start request, active-low level.
REQ-006 stopn  input  1  stop/pause request, active-low level.
REQ-007 clearn  input  1  clear request, active-low level.
REQ-008 door_closed  input  1  1 = door closed.
REQ-009 key_valid  input  1  one-clk pulse qualifying key_digit.
REQ-010 key_digit  input  4  BCD keypad digit; values 10-15 invalid.
REQ-011 mag_on  output  1  magnetron enable.
REQ-012 timer_done  output  1  cook time expired.
REQ-013 time_bcd  output  16  {min_tens, min_units, sec_tens, sec_units} remaining time.
REQ-014 state  output  2  current FSM state code.

Function
REQ-015 FSM states SHALL be IDLE=0, COOK=1, PAUSE=2, DONE=3.
REQ-016 Request priority per cycle SHALL be: clear > door open > stop > start > tick > key.
REQ-017 clearn=0 in any state SHALL, next edge: state IDLE, time_bcd 0x0000.
REQ-018 In IDLE, valid key (key_valid=1, key_digit<=9) SHALL shift time_bcd left one digit, inserting key_digit at sec_units; oldest digit discarded.
REQ-019 Invalid digits (10-15) and key presses outside IDLE SHALL be ignored.
REQ-020 IDLE->COOK SHALL occur when startn=0, door_closed=1, time_bcd!=0; otherwise start is ignored.
REQ-021 In COOK, tick_1hz=1 SHALL decrement time_bcd by one second on the same edge.
REQ-022 Decrement: sec_units borrows from sec_tens; sec 00 borrows one minute and becomes 59; each digit stays 0-9.
REQ-023 Entered seconds 60-99 SHALL be kept and counted down unchanged (e.g. 01:99 -> 01:98).
REQ-024 Tick at 00:01 in COOK SHALL give time 00:00 and state DONE on the same edge.
REQ-025 COOK->PAUSE SHALL occur on door_closed=0 or stopn=0; a tick in that cycle SHALL NOT decrement.
REQ-026 PAUSE->COOK SHALL occur on startn=0 with door_closed=1 and stopn=1; time retained.
REQ-027 In DONE, start, stop, ticks and keys SHALL be ignored; exit only by clear (REQ-017).
REQ-028 mag_on SHALL equal (state==COOK) AND door_closed, combinationally, so it drops in the same cycle the door opens.
REQ-029 timer_done SHALL equal (state==DONE).
REQ-030 time_bcd and state SHALL be registered outputs.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, time_bcd 0x0000, mag_on 0, timer_done 0.
REQ-032 rst asserted mid-COOK SHALL drop mag_on asynchronously, not waiting for clk.
REQ-033 After rst release, first active edge SHALL evaluate inputs normally.

Structure
REQ-034 Shared package SHALL hold: state enum/codes, 4-bit BCD digit type, IDLE/COOK/PAUSE/DONE constants, SEC_WRAP=5/9 constants.
REQ-035 BCD mm:ss down-counter SHALL be a sub-module bcd_mmss_down (load/shift, dec, is_zero, is_one outputs); FSM stays in cook_timer_ctrl.

Verification
REQ-036 Keys 1,3,0 in IDLE, start, door closed -> time_bcd 0x0130, COOK, mag_on=1; 90 ticks -> 0x0000, DONE, timer_done=1, mag_on=0.
REQ-037 COOK at 0x0100, one tick -> 0x0059; keys 1,2,3,4,5 in IDLE -> 0x2345.
REQ-038 COOK at 0x0020, door opens with simultaneous tick -> mag_on=0 same cycle, PAUSE, time stays 0x0020; door closes, startn=0 -> COOK, 0x0020.
REQ-039 Start with time 0x0000 or door open in IDLE -> remains IDLE, mag_on=0; key 0xB -> time unchanged.
REQ-040 rst pulse mid-COOK at 0x0045 -> mag_on=0 before next clk edge, IDLE, 0x0000; clearn=0 in DONE -> IDLE, timer_done=0.
